// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot-product MAC array.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    OUT    = 2'd3
  } state_e;

  typedef enum logic {
    ACT_NONE = 1'b0,
    ACT_RELU = 1'b1
  } act_mode_e;

  // Wide enough for any saturation input any lane can produce.
  localparam int unsigned SAT_W = 128;

  // Accumulator width: full product, one growth bit per doubling of length, plus bias headroom.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned max_len);
    return 2 * width + $unsigned($clog2(max_len)) + 1;
  endfunction

  // Clamp a signed value into the signed range of the given width.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] x,
                                                         input int unsigned width);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
    min_v = ~max_v;
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end
    return x;
  endfunction

endpackage

// File: rtl/dot_product_lane.sv
// One MAC lane: accumulator plus bias/shift/ReLU/saturate post-processing.
// Optional macro DPU_ROUND_EN: round half up before the fixed-point shift.
module dot_product_lane
  import dot_product_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             active_in,
  input  logic [WIDTH-1:0] bias_in,
  input  logic             act_relu,
  input  logic             acc_en,
  input  logic             finish,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned ACC_W = acc_width(WIDTH, MAX_LEN);
`ifdef DPU_ROUND_EN
  localparam int unsigned RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic [ACC_W-1:0] RND_INC = (FRAC_BITS > 0) ? (ACC_W'(1) << RND_SH) : '0;
`endif

  logic                    active_q, active_d;
  logic signed [WIDTH-1:0] bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]        res_q, res_d;
  logic signed [2*WIDTH-1:0] prod_c;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] shr_c;

  // Latch job config on load; accumulate accepted beats only for an enabled lane.
  always_comb begin
    active_d = active_q;
    bias_d   = bias_q;
    acc_d    = acc_q;
    prod_c   = $signed(a_in) * $signed(b_in);
    if (load) begin
      active_d = active_in;
      bias_d   = $signed(bias_in);
      acc_d    = '0;
    end else if (acc_en && active_q) begin
      acc_d = acc_q + ACC_W'(prod_c);
    end
  end

  // Bias, fixed-point shift, optional ReLU and saturation captured in the finish cycle.
  always_comb begin
    sum_c = acc_q + ACC_W'(bias_q);
`ifdef DPU_ROUND_EN
    sum_c = sum_c + $signed(RND_INC);
`endif
    shr_c = sum_c >>> FRAC_BITS;
    if (act_relu && shr_c[ACC_W-1]) begin
      shr_c = '0;
    end
    res_d = res_q;
    if (finish) begin
      res_d = active_q ? WIDTH'(sat_signed(SAT_W'(shr_c), WIDTH)) : '0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      bias_q   <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else begin
      active_q <= active_d;
      bias_q   <= bias_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/dot_product_mac_array.sv
// Parallel dot-product MAC array: job FSM, beat counter and handshakes around NUM_UNITS lanes.
// Optional macro DPU_ROUND_EN (handled in the lanes): round half up before the shift.
module dot_product_mac_array
  import dot_product_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_UNITS = 16,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(MAX_LEN+1)-1:0] vec_len,
  input  logic                         act_mode,
  input  logic [NUM_UNITS-1:0]         active_units,
  input  logic [NUM_UNITS*WIDTH-1:0]   bias_array,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_UNITS*WIDTH-1:0]   a_in_array,
  input  logic [NUM_UNITS*WIDTH-1:0]   b_in_array,
  output logic [NUM_UNITS*WIDTH-1:0]   relu_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  act_mode_e        mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_c;
  logic             beat_c;
  logic             accept_c;
  logic             finish_c;
  logic             relu_c;
  logic [LEN_W-1:0] len_clamp_c;

  // Handshake and job-control decode.
  always_comb begin
    start_c     = (state_q == IDLE) && start;
    beat_c      = (state_q == ACCUM) && in_valid && in_ready_q;
    accept_c    = (state_q == OUT) && out_valid_q && out_ready;
    finish_c    = (state_q == FINISH);
    relu_c      = (mode_q == ACT_RELU);
    len_clamp_c = (vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len;
  end

  // Next-state, beat counter and latched job parameters.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len_clamp_c;
          mode_d  = act_mode_e'(act_mode);
          beat_d  = '0;
          state_d = (len_clamp_c == '0) ? FINISH : ACCUM;
        end
      end
      ACCUM: begin
        if (beat_c) begin
          beat_d = beat_q + LEN_W'(1);
          if (beat_d == len_q) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = OUT;
      OUT: begin
        if (accept_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
    done_d      = accept_c;
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= ACT_NONE;
      len_q       <= '0;
      beat_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lane
    dot_product_lane #(
      .WIDTH    (WIDTH),
      .MAX_LEN  (MAX_LEN),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (start_c),
      .active_in(active_units[g]),
      .bias_in  (bias_array[g*WIDTH +: WIDTH]),
      .act_relu (relu_c),
      .acc_en   (beat_c),
      .finish   (finish_c),
      .a_in     (a_in_array[g*WIDTH +: WIDTH]),
      .b_in     (b_in_array[g*WIDTH +: WIDTH]),
      .result   (relu_out[g*WIDTH +: WIDTH])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
